// File: rtl/video_fade.sv
// rtl/video_fade.sv - post-blend brightness stage with frame-stepped fade level
// Scales blended RGB by a 4-bit level that steps only on frame edges.
module video_fade #(
    parameter bit         V_SYNC_POLARITY  = 1'b1,
    parameter logic [3:0] FADE_RESET_LEVEL = 4'd15
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [11:0] rgb_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        dv_de_i,
    input  logic        fade_start_i,
    input  logic        fade_dir_i,
    input  logic [3:0]  fade_rate_i,
    input  logic        fade_abort_i,
    output logic [11:0] rgb_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        dv_de_o,
    output logic [3:0]  fade_level_o,
    output logic        fade_busy_o,
    output logic        fade_done_o
);

    typedef enum logic {
        S_IDLE,
        S_STEP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_level;
    logic [3:0]  r_cnt;
    logic        r_dir;
    logic [3:0]  r_rate;
    logic        r_done;
    logic        r_vs_prev;
    logic [11:0] r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_de;

    state_t      w_state_nxt;
    logic [3:0]  w_level_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_dir_nxt;
    logic [3:0]  w_rate_nxt;
    logic        w_done_nxt;
    logic        w_edge;
    logic [3:0]  w_start_target;
    logic [3:0]  w_cur_target;
    logic [3:0]  w_step_level;
    logic [11:0] w_rgb_scaled;

    function automatic logic [3:0] scale_ch(input logic [3:0] c, input logic [3:0] l);
        logic [7:0] p;
        p = {4'd0, c} * ({4'd0, l} + 8'd1);
        return p[7:4];
    endfunction

    assign w_edge         = (r_vs_prev == !V_SYNC_POLARITY) && (vsync_i == V_SYNC_POLARITY);
    assign w_start_target = fade_dir_i ? 4'd15 : 4'd0;
    assign w_cur_target   = r_dir ? 4'd15 : 4'd0;
    assign w_step_level   = r_dir ? r_level + 4'd1 : r_level - 4'd1;
    assign w_rgb_scaled   = {scale_ch(rgb_i[11:8], r_level),
                             scale_ch(rgb_i[7:4],  r_level),
                             scale_ch(rgb_i[3:0],  r_level)};

    // Abort outranks start, and either one masks a coincident frame edge.
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_rate_nxt  = r_rate;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fade_start_i && !fade_abort_i) begin
                    w_dir_nxt  = fade_dir_i;
                    w_rate_nxt = fade_rate_i;
                    w_cnt_nxt  = 4'd0;
                    if (r_level == w_start_target) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_STEP;
                    end
                end
            end
            S_STEP: begin
                if (fade_abort_i) begin
                    w_state_nxt = S_IDLE;
                end else if (fade_start_i) begin
                    w_dir_nxt  = fade_dir_i;
                    w_rate_nxt = fade_rate_i;
                    w_cnt_nxt  = 4'd0;
                    if (r_level == w_start_target) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_edge) begin
                    if (r_cnt == r_rate) begin
                        w_cnt_nxt   = 4'd0;
                        w_level_nxt = w_step_level;
                        if (w_step_level == w_cur_target) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_level <= FADE_RESET_LEVEL;
            r_cnt   <= 4'd0;
            r_dir   <= 1'b0;
            r_rate  <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_rate  <= w_rate_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Previous vsync resets to the active level so a high vsync at release is not a frame edge.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_vs_prev <= V_SYNC_POLARITY;
            r_rgb     <= 12'd0;
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_de      <= 1'b0;
        end else begin
            r_vs_prev <= vsync_i;
            r_rgb     <= dv_de_i ? w_rgb_scaled : 12'd0;
            r_hs      <= hsync_i;
            r_vs      <= vsync_i;
            r_de      <= dv_de_i;
        end
    end

    assign rgb_o        = r_rgb;
    assign hsync_o      = r_hs;
    assign vsync_o      = r_vs;
    assign dv_de_o      = r_de;
    assign fade_level_o = r_level;
    assign fade_busy_o  = (r_state == S_STEP);
    assign fade_done_o  = r_done;

endmodule

// File: tb/tb_video_fade.sv
// tb/tb_video_fade.sv - directed scoreboard bench for video_fade
module tb_video_fade;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [11:0] rgb_i;
    logic        hsync_i;
    logic        vsync_i;
    logic        dv_de_i;
    logic        fade_start_i;
    logic        fade_dir_i;
    logic [3:0]  fade_rate_i;
    logic        fade_abort_i;
    logic [11:0] rgb_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        dv_de_o;
    logic [3:0]  fade_level_o;
    logic        fade_busy_o;
    logic        fade_done_o;

    video_fade dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .rgb_i        (rgb_i),
        .hsync_i      (hsync_i),
        .vsync_i      (vsync_i),
        .dv_de_i      (dv_de_i),
        .fade_start_i (fade_start_i),
        .fade_dir_i   (fade_dir_i),
        .fade_rate_i  (fade_rate_i),
        .fade_abort_i (fade_abort_i),
        .rgb_o        (rgb_o),
        .hsync_o      (hsync_o),
        .vsync_o      (vsync_o),
        .dv_de_o      (dv_de_o),
        .fade_level_o (fade_level_o),
        .fade_busy_o  (fade_busy_o),
        .fade_done_o  (fade_done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic        h;
        logic        v;
        logic        de;
    } px_t;

    px_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  exp_level;

    function automatic logic [11:0] model_scale(input logic [11:0] c, input int l, input logic de);
        int r, g, b;
        if (!de) return 12'd0;
        r = (int'(c[11:8]) * (l + 1)) / 16;
        g = (int'(c[7:4])  * (l + 1)) / 16;
        b = (int'(c[3:0])  * (l + 1)) / 16;
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic px(input logic [11:0] c, input logic h, input logic v, input logic de);
        px_t e;
        rgb_i   = c;
        hsync_i = h;
        vsync_i = v;
        dv_de_i = de;
        if (reset_i) sb.push_back('0);
        else         sb.push_back({model_scale(c, exp_level, de), h, v, de});
        @(posedge clk);
        #1;
        fade_start_i = 1'b0;
        fade_abort_i = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rgb_o",   {20'd0, rgb_o}, {20'd0, e.rgb});
            chk("hsync_o", {31'd0, hsync_o}, {31'd0, e.h});
            chk("vsync_o", {31'd0, vsync_o}, {31'd0, e.v});
            chk("dv_de_o", {31'd0, dv_de_o}, {31'd0, e.de});
        end
    endtask

    task automatic rpx(input logic v);
        px(12'($urandom), 1'($urandom), v, 1'($urandom));
    endtask

    task automatic state_chk(input string tag, input int lvl, input logic busy, input logic done);
        chk({tag, "_level"}, {28'd0, fade_level_o}, 32'(lvl));
        chk({tag, "_busy"},  {31'd0, fade_busy_o},  {31'd0, busy});
        chk({tag, "_done"},  {31'd0, fade_done_o},  {31'd0, done});
    endtask

    task automatic vedge(input int new_level, input logic done, input logic busy);
        rpx(1'b1);
        exp_level = new_level;
        state_chk("edge", new_level, busy, done);
        rpx(1'b0);
        chk("edge_done_low", {31'd0, fade_done_o}, 32'd0);
    endtask

    task automatic start(input logic dir, input logic [3:0] rate);
        fade_start_i = 1'b1;
        fade_dir_i   = dir;
        fade_rate_i  = rate;
        rpx(1'b0);
    endtask

    initial begin
        reset_i      = 1'b1;
        rgb_i        = '0;
        hsync_i      = 1'b0;
        vsync_i      = 1'b0;
        dv_de_i      = 1'b0;
        fade_start_i = 1'b0;
        fade_dir_i   = 1'b0;
        fade_rate_i  = '0;
        fade_abort_i = 1'b0;
        exp_level    = 15;
        px(12'h000, 1'b0, 1'b0, 1'b0);
        px(12'h000, 1'b0, 1'b0, 1'b0);
        reset_i = 1'b0;
        state_chk("reset", 15, 1'b0, 1'b0);
        chk("reset_rgb", {20'd0, rgb_o}, 32'd0);

        px(12'hFA5, 1'b0, 1'b0, 1'b1);
        chk("scale_l15", {20'd0, rgb_o}, 32'h00000FA5);

        // full fade out at rate 0: one step per edge, done on the 15th
        start(1'b0, 4'd0);
        state_chk("fo_start", 15, 1'b1, 1'b0);
        for (int k = 1; k <= 15; k++) vedge(15 - k, k == 15, k != 15);
        px(12'hFA5, 1'b0, 1'b0, 1'b1);
        chk("scale_l0", {20'd0, rgb_o}, 32'h0);

        // fade in to 7 and hold there via abort
        start(1'b1, 4'd0);
        for (int k = 1; k <= 7; k++) vedge(k, 1'b0, 1'b1);
        fade_abort_i = 1'b1;
        rpx(1'b0);
        state_chk("abort7", 7, 1'b0, 1'b0);
        px(12'hFA5, 1'b0, 1'b0, 1'b1);
        chk("scale_l7", {20'd0, rgb_o}, 32'h00000752);

        start(1'b0, 4'd0);
        for (int k = 1; k <= 7; k++) vedge(7 - k, k == 7, k != 7);

        // fade in at rate 2: a step every third edge
        start(1'b1, 4'd2);
        state_chk("fi_start", 0, 1'b1, 1'b0);
        for (int k = 1; k <= 45; k++) vedge(k / 3, k == 45, k != 45);
        px(12'hFA5, 1'b1, 1'b0, 1'b0);
        chk("de_off", {20'd0, rgb_o}, 32'h0);

        // start while already at target
        start(1'b1, 4'd3);
        state_chk("at_target", 15, 1'b0, 1'b1);
        rpx(1'b0);
        state_chk("at_target_after", 15, 1'b0, 1'b0);

        // abort after 5 edges
        start(1'b0, 4'd0);
        for (int k = 1; k <= 5; k++) vedge(15 - k, 1'b0, 1'b1);
        fade_abort_i = 1'b1;
        rpx(1'b0);
        state_chk("abort10", 10, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) vedge(10, 1'b0, 1'b0);

        // random sync patterns while idle
        for (int k = 0; k < 24; k++) rpx(1'($urandom));
        rpx(1'b0);
        state_chk("rand_idle", 10, 1'b0, 1'b0);

        // start coincident with a frame edge does not step
        fade_start_i = 1'b1;
        fade_dir_i   = 1'b0;
        fade_rate_i  = 4'd0;
        rpx(1'b1);
        state_chk("start_on_edge", 10, 1'b1, 1'b0);
        rpx(1'b0);
        vedge(9, 1'b0, 1'b1);

        // reset mid-fade
        reset_i = 1'b1;
        rpx(1'b0);
        reset_i   = 1'b0;
        exp_level = 15;
        state_chk("mid_reset", 15, 1'b0, 1'b0);
        rpx(1'b0);
        vedge(15, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
